// File: rtl/normalizer_seq_pkg.sv
// normalizer_seq_pkg: state encoding and default width shared by the normalizer block.
package normalizer_seq_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;
   localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/normalizer_seq_if.sv
// normalizer_seq_if: operand/result handshake bundle for the normalizer.
interface normalizer_seq_if import normalizer_seq_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [SHW-1:0]   out_shamt;
   logic             out_zero;
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_shamt, out_zero);
   modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_shamt, out_zero);
endinterface

// File: rtl/normalizer_step.sv
// normalizer_step: one binary-search probe; tests the masked top bits and offers the shifted word.
module normalizer_step #(
   parameter int WIDTH = 32,
   parameter int SHW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_work,
   input  logic [SHW-1:0]   i_step,
   input  logic [WIDTH-1:0] i_mask,
   output logic [WIDTH-1:0] o_work,
   output logic             o_zero
);
   assign o_work = i_work << i_step;
   assign o_zero = (i_work & i_mask) == '0;
endmodule

// File: rtl/normalizer_seq.sv
// normalizer_seq: multi-cycle left normalizer resolving one shift-amount bit per cycle, MSB first.
module normalizer_seq import normalizer_seq_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SHW = $clog2(WIDTH)
) (
   input logic              clk,
   input logic              rst,
   normalizer_seq_if.slave  bus
);
   state_t           r_state;
   state_t           w_state_n;
   logic [WIDTH-1:0] r_work;
   logic [SHW-1:0]   r_shamt;
   logic [SHW-1:0]   r_k;
   logic [WIDTH-1:0] r_odata;
   logic [SHW-1:0]   r_oshamt;
   logic             r_ozero;
   logic [SHW-1:0]   w_step;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_shift;
   logic             w_zero;
   logic [WIDTH-1:0] w_work_n;
   logic [SHW-1:0]   w_shamt_n;
   assign w_step    = SHW'(1) << r_k;
   assign w_mask    = ~({WIDTH{1'b1}} >> w_step);
   assign w_work_n  = w_zero ? w_shift : r_work;
   assign w_shamt_n = w_zero ? (r_shamt | w_step) : r_shamt;
   normalizer_step #(.WIDTH(WIDTH), .SHW(SHW)) u_step (
      .i_work (r_work),
      .i_step (w_step),
      .i_mask (w_mask),
      .o_work (w_shift),
      .o_zero (w_zero)
   );
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_n;
   end
   always_comb begin
      w_state_n = r_state == IDLE   ? (bus.in_valid ? SEARCH : IDLE) :
                  r_state == SEARCH ? (r_k == '0 ? DONE : SEARCH) :
                  (r_state != DONE || bus.out_ready) ? IDLE : DONE;
      bus.in_ready  = r_state == IDLE;
      bus.out_valid = r_state == DONE;
   end
   // Result registers are separate from the search state so outputs stay put outside DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work   <= '0;
         r_shamt  <= '0;
         r_k      <= '0;
         r_odata  <= '0;
         r_oshamt <= '0;
         r_ozero  <= 1'b0;
      end else if (r_state == IDLE && bus.in_valid) begin
         r_work  <= bus.in_data;
         r_shamt <= '0;
         r_k     <= SHW'(SHW - 1);
      end else if (r_state == SEARCH) begin
         r_work  <= w_work_n;
         r_shamt <= w_shamt_n;
         r_k     <= r_k - SHW'(1);
         if (r_k == '0) begin
            r_odata  <= w_work_n;
            r_oshamt <= w_shamt_n;
            r_ozero  <= w_work_n == '0;
         end
      end
   end
   assign bus.out_data  = r_odata;
   assign bus.out_shamt = r_oshamt;
   assign bus.out_zero  = r_ozero;
endmodule

// File: tb/tb_normalizer_seq.sv
// tb_normalizer_seq: directed and random checks of the normalizer against hand values and a CLZ model.
module tb_normalizer_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tot = 0;
   int   n_bad = 0;
   normalizer_seq_if #(.WIDTH(32)) bus ();
   normalizer_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic int clz(input logic [31:0] v);
      for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
      return 31;
   endfunction
   task automatic xfer(input string tag, input logic [31:0] d, input logic [31:0] e_data,
                       input logic [4:0] e_sh, input logic e_z, input int stall);
      int cnt;
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.out_ready = stall == 0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      chk({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
      cnt = 0;
      while (!bus.out_valid && cnt < 20) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, ".lat"}, cnt, 32'd5);
      chk({tag, ".data"}, bus.out_data, e_data);
      chk({tag, ".shamt"}, 32'(bus.out_shamt), 32'(e_sh));
      chk({tag, ".zero"}, 32'(bus.out_zero), 32'(e_z));
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (stall > 0) begin
         chk({tag, ".hold_v"}, 32'(bus.out_valid), 32'd1);
         chk({tag, ".hold_d"}, bus.out_data, e_data);
         chk({tag, ".hold_s"}, 32'(bus.out_shamt), 32'(e_sh));
         chk({tag, ".hold_r"}, 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".idle_r"}, 32'(bus.in_ready), 32'd1);
      chk({tag, ".idle_v"}, 32'(bus.out_valid), 32'd0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic [31:0] d;
      int          z;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst.out_data", bus.out_data, 32'd0);
      chk("rst.out_shamt", 32'(bus.out_shamt), 32'd0);
      chk("rst.out_zero", 32'(bus.out_zero), 32'd0);
      xfer("one",   32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0, 0);
      xfer("msb",   32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0, 0);
      xfer("f0",    32'h00F0_0000, 32'hF000_0000, 5'd8,  1'b0, 0);
      xfer("zero",  32'h0000_0000, 32'h0000_0000, 5'd31, 1'b1, 0);
      xfer("stall", 32'h0001_2345, 32'h91A2_8000, 5'd15, 1'b0, 10);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1234_5678;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort.out_data", bus.out_data, 32'd0);
      chk("abort.out_shamt", 32'(bus.out_shamt), 32'd0);
      chk("abort.out_zero", 32'(bus.out_zero), 32'd0);
      xfer("after", 32'h4000_0000, 32'h8000_0000, 5'd1, 1'b0, 0);
      for (int n = 0; n < 2000; n++) begin
         d = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 15) == 0) d = '0;
         z = clz(d);
         xfer("rnd", d, d << z, 5'(z), d == '0, int'($urandom_range(0, 3)));
      end
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
